// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: front-end fetch stage. Owns the PC and drives the
// address of a combinational 4-word line ROM. Each cycle it pushes the usable
// words of the returned line into an instruction FIFO. It hands {instr, pc}
// pairs to dispatch one per cycle over a valid/ready handshake.
// A redirect (jmp_en) flushes the FIFO and reloads the PC.
// Optional feature macro: IFQ_PERF_CNT_EN adds the flush_cnt and stall_cnt
// counter outputs.
module instr_fetch_queue #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [31:0]  rom_addr,
    input  logic [127:0] rom_data,
    input  logic         jmp_en,
    input  logic [31:0]  jmp_addr,
    input  logic         dq_ready,
    output logic         dq_valid,
    output logic [31:0]  dq_instr,
    output logic [31:0]  dq_pc
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]  flush_cnt,
    output logic [31:0]  stall_cnt
`endif
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic [1:0]   off;
    logic [2:0]   push_n;
    logic [AW:0]  free;
    logic         push;
    logic         pop;
    logic [127:0] line_shift;

    // Push size comes from the word offset within the line. Free space is
    // measured before this cycle's pop, so a simultaneous pop gives no credit.
    always_comb begin
        off        = pc[3:2];
        push_n     = 3'd4 - {1'b0, off};
        free       = DEPTH_C - count;
        push       = ~jmp_en & (free >= (AW+1)'(push_n));
        pop        = dq_valid & dq_ready;
        line_shift = rom_data >> {off, 5'b0};
    end

    // Outputs are forced to zero while the queue is empty.
    always_comb begin
        rom_addr = pc;
        dq_valid = (count != '0) & ~jmp_en;
        dq_instr = (count != '0) ? instr_mem[rd_ptr] : 32'h0;
        dq_pc    = (count != '0) ? pc_mem[rd_ptr]    : 32'h0;
    end

    // Control state: PC, pointers and occupancy. Reset dominates redirect,
    // and redirect dominates push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (jmp_en) begin
            pc     <= {jmp_addr[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(push_n);
                pc     <= {pc[31:4] + 28'd1, 4'b0000};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (push ? (AW+1)'(push_n) : '0) - (pop ? (AW+1)'(1) : '0);
        end
    end

    // FIFO storage. Word off+j of the line lands in slot wr_ptr+j. Storage is
    // not reset because the outputs are gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int j = 0; j < 4; j++) begin
                if (3'(j) < push_n) begin
                    instr_mem[wr_ptr + AW'(j)] <= line_shift[32*j +: 32];
                    pc_mem[wr_ptr + AW'(j)]    <= pc + (32'(j) << 2);
                end
            end
        end
    end

`ifdef IFQ_PERF_CNT_EN
    // Performance counters: redirect cycles, and cycles where fetch stalled
    // on a full queue. Both wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else if (jmp_en) begin
            flush_cnt <= flush_cnt + 32'd1;
        end else if (!push) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
